// File: rtl/ae_pkg.sv
// Shared definitions for the memory-sequenced dot-product engine: FSM encoding,
// accumulator sizing and signed saturation bounds.
package ae_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Wide enough for 2^aw full-scale products, so the sum can never overflow.
    function automatic int acc_width(int aw, int dw);
        return 2 * dw + aw;
    endfunction

    function automatic longint sat_max(int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Job control, memory and host-load bus for mem_seq. The slave modport is the
// sequencer side; the master side holds the host and the memory.
interface mem_seq_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_read_addr_1;
    logic [ADDR_WIDTH-1:0] mem_read_addr_2;
    logic [DATA_WIDTH-1:0] mem_read_data_1;
    logic [DATA_WIDTH-1:0] mem_read_data_2;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  host_write_en;
    logic [ADDR_WIDTH-1:0] host_write_addr;
    logic [DATA_WIDTH-1:0] host_write_data;
    logic                  host_write_ready;

    modport master (
        output start, len, base_a, base_b, dest_addr,
        output mem_read_data_1, mem_read_data_2,
        output host_write_en, host_write_addr, host_write_data,
        input  busy, done, mem_read_addr_1, mem_read_addr_2,
        input  mem_write_en, mem_write_addr, mem_write_data, host_write_ready
    );

    modport slave (
        input  start, len, base_a, base_b, dest_addr,
        input  mem_read_data_1, mem_read_data_2,
        input  host_write_en, host_write_addr, host_write_data,
        output busy, done, mem_read_addr_1, mem_read_addr_2,
        output mem_write_en, mem_write_addr, mem_write_data, host_write_ready
    );
endinterface

// File: rtl/mac_unit.sv
// Signed fixed-point multiply, arithmetic rescale and wide accumulate.
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 36
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [ACC_W-1:0]      o_acc
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [2*DATA_WIDTH-1:0] w_shift;
    logic signed [ACC_W-1:0]        r_acc;

    assign w_prod  = i_a * i_b;
    assign w_shift = w_prod >>> FRAC_BITS;

    // NOTE: non-blocking assignments for every register, so all state updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + {{(ACC_W - 2*DATA_WIDTH){w_shift[2*DATA_WIDTH-1]}}, w_shift};
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/mem_seq.sv
// Dot-product sequencer: streams two operand vectors from memory, accumulates,
// writes the saturated result back. Define MEM_SEQ_RELU_EN to clamp negatives to 0.
module mem_seq
    import ae_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    mem_seq_if.slave bus
);
    localparam int ACC_W = acc_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DATA_WIDTH));

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH-1:0] r_rd_addr_1;
    logic [ADDR_WIDTH-1:0] r_rd_addr_2;
    logic [ADDR_WIDTH-1:0] r_dest;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_en;

    logic signed [ACC_W-1:0] w_acc;
    logic                    w_mac_en;
    logic                    w_mac_clr;
    logic [DATA_WIDTH-1:0]   w_wb_data;

    // Read data lags the address by one cycle, so accumulate one cycle behind FETCH.
    assign w_mac_en  = (r_state == S_DRAIN) || ((r_state == S_FETCH) && (r_cnt != '0));
    assign w_mac_clr = (r_state == S_IDLE);

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_a   (bus.mem_read_data_1),
        .i_b   (bus.mem_read_data_2),
        .o_acc (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_rd_addr_1 <= '0;
            r_rd_addr_2 <= '0;
            r_dest      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dest <= bus.dest_addr;
                        r_len  <= bus.len;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_state     <= S_FETCH;
                            r_rd_addr_1 <= bus.base_a;
                            r_rd_addr_2 <= bus.base_b;
                        end else begin
                            r_state <= S_WRITE;
                            r_wr_en <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_cnt == r_len - 1'b1) begin
                        r_state     <= S_DRAIN;
                        r_rd_addr_1 <= '0;
                        r_rd_addr_2 <= '0;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_rd_addr_1 <= r_rd_addr_1 + 1'b1;
                        r_rd_addr_2 <= r_rd_addr_2 + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                    r_wr_en <= 1'b1;
                    r_done  <= 1'b1;
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_wb_data = w_acc[DATA_WIDTH-1:0];
        if (w_acc > SAT_MAX) begin
            w_wb_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_acc < SAT_MIN) begin
            w_wb_data = SAT_MIN[DATA_WIDTH-1:0];
        end
`ifdef MEM_SEQ_RELU_EN
        if (w_wb_data[DATA_WIDTH-1]) begin
            w_wb_data = '0;
        end
`endif
    end

    // Host owns the write port whenever the sequencer is idle; its writes are dropped otherwise.
    always_comb begin
        bus.mem_write_en   = bus.host_write_en;
        bus.mem_write_addr = bus.host_write_addr;
        bus.mem_write_data = bus.host_write_data;
        if (r_busy) begin
            bus.mem_write_en   = r_wr_en;
            bus.mem_write_addr = r_dest;
            bus.mem_write_data = w_wb_data;
        end
    end

    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.host_write_ready = !r_busy;
    assign bus.mem_read_addr_1  = r_rd_addr_1;
    assign bus.mem_read_addr_2  = r_rd_addr_2;
endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: expected writes are queued by the stimulus and
// checked by an independent write-port monitor.
module tb_mem_seq;
    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            busy_cycles;
        bit            seq;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   busy_cnt;
    exp_t sb[$];
    logic [DW-1:0] mem [2**AW];

    mem_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one-cycle read latency.
    always @(posedge clk) begin
        bus.mem_read_data_1 <= mem[bus.mem_read_addr_1];
        bus.mem_read_data_2 <= mem[bus.mem_read_addr_2];
        if (bus.mem_write_en) mem[bus.mem_write_addr] <= bus.mem_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write on the memory port must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.mem_write_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_write_addr", {28'd0, bus.mem_write_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", {28'd0, bus.mem_write_addr}, {28'd0, e.addr});
                    check("wr_data", {16'd0, bus.mem_write_data}, {16'd0, e.data});
                    check("wr_done", {31'd0, bus.done}, {31'd0, e.seq});
                    if (e.seq) check("busy_cycles", busy_cnt, e.busy_cycles);
                end
            end
            if (!bus.busy) busy_cnt = 0;
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e = '{addr: a, data: d, busy_cycles: 0, seq: 1'b0};
        sb.push_back(e);
        bus.host_write_en   = 1'b1;
        bus.host_write_addr = a;
        bus.host_write_data = d;
        @(posedge clk); #1;
        bus.host_write_en   = 1'b0;
    endtask

    // Issues start for one cycle; returns 1 time unit into the first busy cycle.
    task automatic start_job(input int n, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                             input logic [AW-1:0] dst, input logic [DW-1:0] exp_d, input bit expect_write);
        if (expect_write) begin
            exp_t e;
            e = '{addr: dst, data: exp_d, busy_cycles: (n == 0) ? 1 : n + 2, seq: 1'b1};
            sb.push_back(e);
        end
        bus.start     = 1'b1;
        bus.len       = (AW + 1)'(n);
        bus.base_a    = ba;
        bus.base_b    = bb;
        bus.dest_addr = dst;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        check({name, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        busy_cnt = 0;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.len             = '0;
        bus.base_a          = '0;
        bus.base_b          = '0;
        bus.dest_addr       = '0;
        bus.host_write_en   = 1'b0;
        bus.host_write_addr = '0;
        bus.host_write_data = '0;

        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_ready", {31'd0, bus.host_write_ready}, 32'd1);
        check("rst_wr_en", {31'd0, bus.mem_write_en}, 32'd0);
        check("rst_raddr", {28'd0, bus.mem_read_addr_1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job: 4 x (1.0 * 2.0) = 8.0 -> 0x0800.
        for (int i = 0; i < 4; i++) host_write(AW'(i), 16'h0100);
        for (int i = 8; i < 12; i++) host_write(AW'(i), 16'h0200);
        start_job(4, 4'd0, 4'd8, 4'd15, 16'h0800, 1'b1);
        wait_done("basic");

        // Wrapped A: mem[14,15,0,1] = 0,0x0800,0x0100,0x0100 against 2.0 -> 0+16+2+2 = 0x1400.
        begin
            logic [AW-1:0] exp_a [4];
            exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
            start_job(4, 4'd14, 4'd8, 4'd13, 16'h1400, 1'b1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("wrap_raddr1", {28'd0, bus.mem_read_addr_1}, {28'd0, exp_a[i]});
                check("wrap_raddr2", {28'd0, bus.mem_read_addr_2}, 32'(8 + i));
            end
            wait_done("wrap");
        end

        // Zero-length job writes 0 after a single busy cycle.
        start_job(0, 4'd0, 4'd0, 4'd5, 16'h0000, 1'b1);
        wait_done("zero_len");

        // Reset in the second FETCH cycle aborts without a write.
        start_job(4, 4'd0, 4'd8, 4'd12, 16'h0000, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_busy",  {31'd0, bus.busy}, 32'd0);
            check("abort_wr_en", {31'd0, bus.mem_write_en}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_partial", {16'd0, mem[12]}, 32'd0);

        // Job after reset, with a host write attempted while busy.
        start_job(4, 4'd0, 4'd8, 4'd14, 16'h0800, 1'b1);
        bus.host_write_en   = 1'b1;
        bus.host_write_addr = 4'd7;
        bus.host_write_data = 16'hDEAD;
        @(negedge clk);
        check("busy_ready", {31'd0, bus.host_write_ready}, 32'd0);
        @(posedge clk); #1;
        bus.host_write_en   = 1'b0;
        wait_done("post_reset");
        check("busy_host_dropped", {16'd0, mem[7]}, 32'd0);

        // Positive saturation: 16 x (127.0 * 127.0).
        for (int i = 0; i < 16; i++) host_write(AW'(i), 16'h7F00);
        start_job(16, 4'd0, 4'd0, 4'd3, 16'h7FFF, 1'b1);
        wait_done("sat_pos");

        // Negative saturation: alternating 127.0 / -127.0, B offset by one.
        for (int i = 0; i < 16; i++) host_write(AW'(i), (i % 2 == 0) ? 16'h7F00 : 16'h8100);
`ifdef MEM_SEQ_RELU_EN
        start_job(16, 4'd0, 4'd1, 4'd2, 16'h0000, 1'b1);
`else
        start_job(16, 4'd0, 4'd1, 4'd2, 16'h8000, 1'b1);
`endif
        wait_done("sat_neg");

        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end
endmodule
